piso_serializer: RTL



---
 rtl/piso_pkg.sv | 29 ++
 rtl/bit_counter.sv | 39 +++
 rtl/piso_serializer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Purpose : shared definitions for the parallel-in/serial-out serializer
//           (state encoding, counter width helper).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package piso_pkg;

   // State encoding shared with the future deserializer so traces line up.
   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   typedef enum logic {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT
   } state_t;

   // Bits needed to hold the values 0..n-1; never less than 1 so that a
   // degenerate count still yields a legal vector.
   function automatic int cnt_w(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < n) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage : piso_pkg

// File: rtl/bit_counter.sv
// Purpose : bit-position counter 0..MAX with clear/increment and an at_max flag.
// Latency : count updates one cycle after clear/inc; at_max is combinational on count.
// Backpressure: none; increments saturate at MAX, clear has priority over inc.
//
// Ports:
//   clock, reset_n : rising-edge clock, synchronous active-low reset
//   clear          : return count to 0 on the next edge
//   inc            : advance count by one (held at MAX)
//   count          : current bit position
//   at_max         : count == MAX
module bit_counter
   import piso_pkg::*;
#(
   parameter int MAX = 3,
   parameter int CW  = cnt_w(MAX + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          at_max
);

   always_comb begin
      at_max = (count == CW'(MAX));
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + 1'b1;
      end
   end

endmodule : bit_counter

// File: rtl/piso_serializer.sv
// Purpose : parallel-in, serial-out shifter with first/last framing strobes,
//           MSB- or LSB-first, advancing one bit per bit_en tick.
// Latency : first bit visible 1 cycle after the accept edge; a word takes
//           WIDTH bit_en ticks, and back-to-back words run with no gap.
// Backpressure: in_ready is high in IDLE and on the last-bit tick only; in_valid
//           while in_ready is low is ignored and the producer must hold in_data.
//
// Ports:
//   clock, reset_n      : rising-edge clock, synchronous active-low reset
//   in_data/in_valid    : parallel word offered by the producer
//   in_ready            : word is taken this cycle if in_valid is also high
//   bit_en              : bit-rate tick; serial position moves only when high
//   ser_out/ser_valid   : serial bit and its qualifier (IDLE_LEVEL when idle)
//   ser_first/ser_last  : framing strobes on the first/last bit of a word
//   busy                : frame in progress (same as ser_valid)
module piso_serializer
   import piso_pkg::*;
#(
   parameter int   WIDTH      = 4,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             bit_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

   localparam int CNT_W = cnt_w(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   shreg;
   logic [WIDTH-1:0]   shreg_nxt;
   logic [CNT_W-1:0]   bit_cnt;
   logic               at_max;
   logic               tick;
   logic               accept;
   logic               cnt_clear;
   logic               cnt_inc;

   bit_counter #(
      .MAX (WIDTH - 1),
      .CW  (CNT_W)
   ) u_bit_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (cnt_clear),
      .inc     (cnt_inc),
      .count   (bit_cnt),
      .at_max  (at_max)
   );

   // Handshake: ready never looks at in_valid, so a producer may wait on it.
   // Opening on the last-bit tick lets the next word load on the same edge
   // that would otherwise drop to IDLE, giving gap-free back-to-back output.
   always_comb begin
      tick     = (state == S_SHIFT) && bit_en;
      in_ready = (state == S_IDLE) || (tick && at_max);
      accept   = in_valid && in_ready;
   end

   // Next-state, shift register and counter control.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;

      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_SHIFT;
               shreg_nxt = in_data;
               cnt_clear = 1'b1;
            end
         end

         S_SHIFT: begin
            if (bit_en) begin
               if (at_max) begin
                  // Word done: reload if a new one is waiting, else go idle.
                  cnt_clear = 1'b1;
                  if (accept) begin
                     shreg_nxt = in_data;
                  end else begin
                     state_nxt = S_IDLE;
                     shreg_nxt = '0;
                  end
               end else begin
                  // Move the next bit to the output end; vacated bits are 0.
                  cnt_inc = 1'b1;
                  if (MSB_FIRST) begin
                     shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                  end else begin
                     shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
                  end
               end
            end
         end

         default: begin
            state_nxt = S_IDLE;
            shreg_nxt = '0;
            cnt_clear = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= S_IDLE;
         shreg <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
      end
   end

   // Serial side is a pure decode of registered state.
   always_comb begin
      ser_valid = (state == S_SHIFT);
      busy      = ser_valid;
      ser_first = ser_valid && (bit_cnt == '0);
      ser_last  = ser_valid && at_max;
      if (!ser_valid) begin
         ser_out = IDLE_LEVEL;
      end else if (MSB_FIRST) begin
         ser_out = shreg[WIDTH-1];
      end else begin
         ser_out = shreg[0];
      end
   end

endmodule : piso_serializer
